// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Brief    : Shared SDRAM command encodings and refresh FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

    localparam int PALL_BIT = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_PRE_WAIT  = 3'd2,
        ST_AREF      = 3'd3,
        ST_AREF_WAIT = 3'd4,
        ST_DONE      = 3'd5
    } ref_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_ref_timer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_ref_timer
// Brief    : Refresh interval counter and saturating postponed-refresh debt.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL  = 390,
    parameter int MAX_DEBT      = 8,
    parameter int URGENT_THRESH = 4,
    parameter int DEBT_W        = $clog2(MAX_DEBT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init_end,
    input  logic              i_aref_issued,
    output logic [DEBT_W-1:0] o_debt,
    output logic [DEBT_W-1:0] o_debt_next,
    output logic              o_urgent,
    output logic              o_overflow
);

    localparam int                CNT_W      = $clog2(REF_INTERVAL);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(REF_INTERVAL - 1);
    localparam logic [DEBT_W-1:0] C_DEBT_MAX = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0] C_URGENT   = DEBT_W'(URGENT_THRESH);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEBT_W-1:0] debt_q, debt_d;
    logic              urgent_q, urgent_d;
    logic              overflow_q, overflow_d;
    logic              w_tick;

    always_comb begin
        w_tick     = i_init_end && (cnt_q == C_CNT_LAST);
        cnt_d      = '0;
        debt_d     = debt_q;
        overflow_d = 1'b0;

        if (i_init_end && !w_tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A tick and an AREF in the same cycle cancel each other out.
        if (w_tick && !i_aref_issued) begin
            if (debt_q == C_DEBT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                debt_d = debt_q + 1'b1;
            end
        end else if (!w_tick && i_aref_issued && (debt_q != '0)) begin
            debt_d = debt_q - 1'b1;
        end

        urgent_d = (debt_d >= C_URGENT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            debt_q     <= '0;
            urgent_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            debt_q     <= debt_d;
            urgent_q   <= urgent_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_debt      = debt_q;
    assign o_debt_next = debt_d;
    assign o_urgent    = urgent_q;
    assign o_overflow  = overflow_q;

endmodule
`default_nettype wire

// File: rtl/sdram_aref_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdram_aref_ctrl
// Brief    : SDRAM auto-refresh engine: debt tracking, arbiter request and
//            PRE-ALL + AREF burst sequencing with tRP/tRFC spacing.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_aref_ctrl
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL  = 390,
    parameter int AREF_PER_REQ  = 1,
    parameter int MAX_DEBT      = 8,
    parameter int URGENT_THRESH = 4,
    parameter int T_RP          = 2,
    parameter int T_RFC         = 7,
    parameter int PRE_EN        = 1,
    parameter int ADDR_W        = 13,
    parameter int DEBT_W        = $clog2(MAX_DEBT + 1)
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              flag_init_end,
    input  logic              ref_en,
    output logic              ref_req,
    output logic              ref_urgent,
    output logic              flag_ref_end,
    output logic [3:0]        aref_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DEBT_W-1:0] ref_debt,
    output logic              ref_overflow
);

    localparam int                WAIT_MAX    = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int                WAIT_W      = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] C_RP_LOAD   = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0] C_RFC_LOAD  = WAIT_W'(T_RFC - 1);
    localparam logic [DEBT_W-1:0] C_PER_REQ   = DEBT_W'(AREF_PER_REQ);
    localparam logic [ADDR_W-1:0] C_ADDR_PALL = ADDR_W'(1 << PALL_BIT);
    localparam ref_state_t        C_FIRST_ST  = (PRE_EN != 0) ? ST_PRE : ST_AREF;

    ref_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DEBT_W-1:0] burst_n_q, burst_n_d;
    logic [DEBT_W-1:0] aref_cnt_q, aref_cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              end_q, end_d;

    logic              w_aref_issued;
    logic [DEBT_W-1:0] w_debt;
    logic [DEBT_W-1:0] w_debt_next;

    assign w_aref_issued = (state_q == ST_AREF);

    sdram_ref_timer #(
        .REF_INTERVAL  (REF_INTERVAL),
        .MAX_DEBT      (MAX_DEBT),
        .URGENT_THRESH (URGENT_THRESH),
        .DEBT_W        (DEBT_W)
    ) u_timer (
        .clk           (sclk),
        .rst           (reset),
        .i_init_end    (flag_init_end),
        .i_aref_issued (w_aref_issued),
        .o_debt        (w_debt),
        .o_debt_next   (w_debt_next),
        .o_urgent      (ref_urgent),
        .o_overflow    (ref_overflow)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        burst_n_d  = burst_n_q;
        aref_cnt_d = aref_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // req_q already implies IDLE, init done and a non-zero debt.
                if (ref_en && req_q) begin
                    burst_n_d  = (w_debt > C_PER_REQ) ? C_PER_REQ : w_debt;
                    aref_cnt_d = '0;
                    state_d    = C_FIRST_ST;
                end
            end
            ST_PRE: begin
                wait_d  = C_RP_LOAD;
                state_d = ST_PRE_WAIT;
            end
            ST_PRE_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_AREF;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_AREF: begin
                aref_cnt_d = aref_cnt_q + 1'b1;
                wait_d     = C_RFC_LOAD;
                state_d    = ST_AREF_WAIT;
            end
            ST_AREF_WAIT: begin
                if (wait_q == '0) begin
                    state_d = (aref_cnt_q < burst_n_q) ? ST_AREF : ST_DONE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state they describe.
        case (state_d)
            ST_PRE:  cmd_d = CMD_PRE;
            ST_AREF: cmd_d = CMD_AREF;
            default: cmd_d = CMD_NOP;
        endcase
        addr_d = (state_d == ST_PRE) ? C_ADDR_PALL : '0;
        end_d  = (state_d == ST_DONE);
        req_d  = (w_debt_next != '0) && (state_d == ST_IDLE) && flag_init_end;
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            burst_n_q  <= '0;
            aref_cnt_q <= '0;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            req_q      <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            burst_n_q  <= burst_n_d;
            aref_cnt_q <= aref_cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            end_q      <= end_d;
        end
    end

    assign ref_req      = req_q;
    assign flag_ref_end = end_q;
    assign aref_cmd     = cmd_q;
    assign sdram_addr   = addr_q;
    assign ref_debt     = w_debt;

endmodule
`default_nettype wire
